// File: rtl/imm_ext_stream.sv
//=============================================================================
// Module   : imm_ext_stream
// Purpose  : Pipelined immediate extender / negator with a valid/ready input,
//            one registered arithmetic stage (S1) and a DEPTH-entry output
//            FIFO that absorbs ALU back-pressure.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            in_valid/in_ready        - input handshake
//            in_imm [IN_W], in_op [2] - 00 sext, 01 zext, 10 -sext,
//                                       11 sext << SHIFT
//            out_valid/out_ready      - output handshake (FIFO head)
//            out_data [OUT_W]         - FIFO head result
//            fifo_level               - FIFO occupancy 0..DEPTH
//            stat_count, stat_stall   - only with IMM_EXT_STATS_EN defined:
//                                       pop counter and sticky stall flag
// Revision : 1.0 - initial release
//=============================================================================
`default_nettype none

module imm_ext_stream #(
   parameter int IN_W  = 12,
   parameter int OUT_W = 32,
   parameter int DEPTH = 4,
   parameter int SHIFT = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [IN_W-1:0]            in_imm,
   input  logic [1:0]                 in_op,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [OUT_W-1:0]           out_data,
   output logic [$clog2(DEPTH):0]     fifo_level
`ifdef IMM_EXT_STATS_EN
   ,
   output logic [31:0]                stat_count,
   output logic                       stat_stall
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0] c_full_level = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0] c_one_level  = LVL_W'(1);
   localparam logic [PTR_W-1:0] c_one_ptr    = PTR_W'(1);

   // Stage S1
   logic              r_s1_valid;
   logic [IN_W-1:0]   r_s1_imm;
   logic [1:0]        r_s1_op;

   // FIFO state
   logic [OUT_W-1:0]  r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wptr;
   logic [PTR_W-1:0]  r_rptr;
   logic [LVL_W-1:0]  r_count;

   logic [OUT_W-1:0]  w_sx;
   logic [OUT_W-1:0]  w_zx;
   logic [OUT_W-1:0]  w_result;
   logic              w_full;
   logic              w_pop;
   logic              w_wr_ok;
   logic              w_push;
   logic              w_accept;

   // ---------------------------------------------------------------------
   // Arithmetic on the S1 word
   // ---------------------------------------------------------------------
   assign w_sx = {{(OUT_W-IN_W){r_s1_imm[IN_W-1]}}, r_s1_imm};
   assign w_zx = {{(OUT_W-IN_W){1'b0}}, r_s1_imm};

   always_comb begin
      w_result = w_sx;
      case (r_s1_op)
         2'b00:   w_result = w_sx;
         2'b01:   w_result = w_zx;
         2'b10:   w_result = -w_sx;
         2'b11:   w_result = w_sx << SHIFT;
         default: w_result = w_sx;
      endcase
   end

   // ---------------------------------------------------------------------
   // Handshakes. A full FIFO still takes a push when its head pops in the
   // same cycle, which keeps throughput at one word per cycle.
   // ---------------------------------------------------------------------
   assign out_valid  = (r_count != '0);
   assign out_data   = r_mem[r_rptr];
   assign fifo_level = r_count;

   assign w_full   = (r_count == c_full_level);
   assign w_pop    = out_valid && out_ready;
   assign w_wr_ok  = !w_full || w_pop;
   assign w_push   = r_s1_valid && w_wr_ok;
   assign in_ready = !r_s1_valid || w_wr_ok;
   assign w_accept = in_valid && in_ready;

   // ---------------------------------------------------------------------
   // S1 register: reloads whenever it is empty or its word leaves this cycle
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_imm   <= '0;
         r_s1_op    <= '0;
      end else if (!r_s1_valid || w_push) begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_imm <= in_imm;
            r_s1_op  <= in_op;
         end
      end
   end

   // FIFO storage carries no reset; occupancy decides what is valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= w_result;
      end
   end

   // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + c_one_ptr;
         if (w_pop)  r_rptr <= r_rptr + c_one_ptr;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_one_level;
            2'b01:   r_count <= r_count - c_one_level;
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef IMM_EXT_STATS_EN
   logic [31:0] r_stat_count;
   logic        r_stat_stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stat_count <= '0;
         r_stat_stall <= 1'b0;
      end else begin
         if (w_pop)                 r_stat_count <= r_stat_count + 32'd1;
         if (in_valid && !in_ready) r_stat_stall <= 1'b1;
      end
   end

   assign stat_count = r_stat_count;
   assign stat_stall = r_stat_stall;
`endif

endmodule

`default_nettype wire
